// File: rtl/dot_position_writer_pkg.sv
// Shared constants, FSM state type and coordinate helpers for the dot-position writer.
// The clamp helpers are only referenced when DOT_WRITER_CLAMP_EN is defined.
package dot_if_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned X_W      = 10;
  localparam int unsigned Y_W      = 9;
  localparam int unsigned IF_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SEND_X,
    SEND_Y,
    DONE
  } state_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } dot_pos_t;

  // Saturate the full unsigned CPU value to the visible area before narrowing.
  function automatic logic [X_W-1:0] clamp_x(input logic [IF_W-1:0] loc);
    return (loc > IF_W'(SCREEN_W - 1)) ? X_W'(SCREEN_W - 1) : loc[X_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] clamp_y(input logic [IF_W-1:0] loc);
    return (loc > IF_W'(SCREEN_H - 1)) ? Y_W'(SCREEN_H - 1) : loc[Y_W-1:0];
  endfunction

endpackage

// File: rtl/dot_position_writer_if.sv
// CPU table-write bus and VGA dot-update bus of the dot-position writer.
// master = the writer itself, slave = CPU/VGA side.
interface dot_position_writer_if;
  import dot_if_pkg::*;

  logic            cpu_wren;
  logic            cpu_is_y;
  logic [IF_W-1:0] cpu_dot_id;
  logic [IF_W-1:0] cpu_loc;

  logic            dotWren;
  logic            is_Yloc;
  logic [IF_W-1:0] dotID;
  logic [IF_W-1:0] dotLoc;

  modport master (
    input  cpu_wren, cpu_is_y, cpu_dot_id, cpu_loc,
    output dotWren, is_Yloc, dotID, dotLoc
  );

  modport slave (
    output cpu_wren, cpu_is_y, cpu_dot_id, cpu_loc,
    input  dotWren, is_Yloc, dotID, dotLoc
  );

endinterface

// File: rtl/dot_position_writer_shadow_table.sv
// Shadow (x,y) table with per-entry dirty bits and a snapshot/clear port.
// A CPU write that lands on the cycle an entry is cleared keeps the entry dirty.
module dot_shadow_table
  import dot_if_pkg::*;
#(
  parameter int unsigned NUM_DOTS = 70,
  parameter int unsigned X_RESET  = 320,
  parameter int unsigned Y_RESET  = 240
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         wr_en_i,
  input  logic                                         wr_is_y_i,
  input  logic [((NUM_DOTS > 1) ? $clog2(NUM_DOTS) : 1)-1:0] wr_id_i,
  input  logic [X_W-1:0]                               wr_x_i,
  input  logic [Y_W-1:0]                               wr_y_i,
  input  logic [((NUM_DOTS > 1) ? $clog2(NUM_DOTS) : 1)-1:0] rd_idx_i,
  input  logic                                         clr_en_i,
  output dot_pos_t                                     rd_pos_c,
  output logic                                         rd_dirty_c
);

  dot_pos_t              table_q [NUM_DOTS];
  logic [NUM_DOTS-1:0]   dirty_q;

  // Write after clear so a same-cycle CPU write re-marks the entry dirty.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_DOTS); i++) begin
        table_q[i] <= '{x: X_W'(X_RESET), y: Y_W'(Y_RESET)};
      end
      dirty_q <= '0;
    end else begin
      if (clr_en_i) begin
        dirty_q[rd_idx_i] <= 1'b0;
      end
      if (wr_en_i) begin
        if (wr_is_y_i) begin
          table_q[wr_id_i].y <= wr_y_i;
        end else begin
          table_q[wr_id_i].x <= wr_x_i;
        end
        dirty_q[wr_id_i] <= 1'b1;
      end
    end
  end

  assign rd_pos_c   = table_q[rd_idx_i];
  assign rd_dirty_c = dirty_q[rd_idx_i];

endmodule

// File: rtl/dot_position_writer.sv
// Frame-synchronous flusher of changed dot positions to the VGA controller.
// Optional coordinate clamping is enabled with the DOT_WRITER_CLAMP_EN macro.
module dot_position_writer
  import dot_if_pkg::*;
#(
  parameter int unsigned NUM_DOTS    = 70,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned X_RESET     = 320,
  parameter int unsigned Y_RESET     = 240
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 screenEnd,
  dot_position_writer_if.master bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 id_err
);

  localparam int unsigned IDX_W = (NUM_DOTS > 1) ? $clog2(NUM_DOTS) : 1;
  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOTS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [Y_W-1:0]      y_snap_q, y_snap_d;
  logic                screen_end_q;
  logic                dot_wren_q, dot_wren_d;
  logic                is_y_q, is_y_d;
  logic [IF_W-1:0]     dot_id_q, dot_id_d;
  logic [IF_W-1:0]     dot_loc_q, dot_loc_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                id_err_q, id_err_d;

  logic                start;
  logic                id_ok;
  logic                clr_en;
  logic [X_W-1:0]      wr_x;
  logic [Y_W-1:0]      wr_y;
  dot_pos_t            rd_pos;
  logic                rd_dirty;

  assign start    = screenEnd & ~screen_end_q;
  assign id_ok    = bus.cpu_dot_id < IF_W'(NUM_DOTS);
  assign id_err_d = bus.cpu_wren & ~id_ok;

`ifdef DOT_WRITER_CLAMP_EN
  assign wr_x = clamp_x(bus.cpu_loc);
  assign wr_y = clamp_y(bus.cpu_loc);
`else
  assign wr_x = bus.cpu_loc[X_W-1:0];
  assign wr_y = bus.cpu_loc[Y_W-1:0];
`endif

  dot_shadow_table #(
    .NUM_DOTS (NUM_DOTS),
    .X_RESET  (X_RESET),
    .Y_RESET  (Y_RESET)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .wr_en_i    (bus.cpu_wren & id_ok),
    .wr_is_y_i  (bus.cpu_is_y),
    .wr_id_i    (IDX_W'(bus.cpu_dot_id)),
    .wr_x_i     (wr_x),
    .wr_y_i     (wr_y),
    .rd_idx_i   (idx_q),
    .clr_en_i   (clr_en),
    .rd_pos_c   (rd_pos),
    .rd_dirty_c (rd_dirty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      y_snap_q     <= '0;
      screen_end_q <= 1'b0;
      dot_wren_q   <= 1'b0;
      is_y_q       <= 1'b0;
      dot_id_q     <= '0;
      dot_loc_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      id_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      y_snap_q     <= y_snap_d;
      screen_end_q <= screenEnd;
      dot_wren_q   <= dot_wren_d;
      is_y_q       <= is_y_d;
      dot_id_q     <= dot_id_d;
      dot_loc_q    <= dot_loc_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      id_err_q     <= id_err_d;
    end
  end

  // Output registers are loaded on the transition into each state so they line up with it.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    y_snap_d     = y_snap_q;
    dot_wren_d   = dot_wren_q;
    is_y_d       = is_y_q;
    dot_id_d     = dot_id_q;
    dot_loc_d    = dot_loc_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    clr_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        if (rd_dirty) begin
          clr_en     = 1'b1;
          state_d    = SEND_X;
          cnt_d      = '0;
          y_snap_d   = rd_pos.y;
          dot_wren_d = 1'b1;
          is_y_d     = 1'b0;
          dot_id_d   = IF_W'(idx_q);
          dot_loc_d  = IF_W'(rd_pos.x);
        end else if (idx_q == LAST_IDX) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      SEND_X: begin
        if (cnt_q == LAST_CNT) begin
          state_d   = SEND_Y;
          cnt_d     = '0;
          is_y_d    = 1'b1;
          dot_loc_d = IF_W'(y_snap_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEND_Y: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d      = '0;
          dot_wren_d = 1'b0;
          is_y_d     = 1'b0;
          dot_id_d   = '0;
          dot_loc_d  = '0;
          if (idx_q == LAST_IDX) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
          end else begin
            state_d = SCAN;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.dotWren = dot_wren_q;
  assign bus.is_Yloc = is_y_q;
  assign bus.dotID   = dot_id_q;
  assign bus.dotLoc  = dot_loc_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign id_err      = id_err_q;

endmodule

// File: tb/tb_dot_position_writer.sv
// Self-checking bench for dot_position_writer: a frame-level model of the shadow
// table predicts the exact per-cycle write stream of every flush.
module tb_dot_position_writer;

  localparam int N    = 70;
  localparam int HOLD = 4;

  typedef struct packed {
    logic        y;
    logic [31:0] id;
    logic [31:0] loc;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic screenEnd = 1'b0;
  logic busy, frame_done, id_err;

  dot_position_writer_if bus();

  dot_position_writer #(
    .NUM_DOTS    (N),
    .HOLD_CYCLES (HOLD),
    .X_RESET     (320),
    .Y_RESET     (240)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .screenEnd  (screenEnd),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .id_err     (id_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int unsigned mx [N];
  int unsigned my [N];
  bit          md [N];
  wr_t         exp_q [$];
  wr_t         cap [$];
  int          bad_idle;

  function automatic int unsigned fit_x(input logic [31:0] v);
`ifdef DOT_WRITER_CLAMP_EN
    if (v > 639) return 639;
`endif
    return v % 1024;
  endfunction

  function automatic int unsigned fit_y(input logic [31:0] v);
`ifdef DOT_WRITER_CLAMP_EN
    if (v > 479) return 479;
`endif
    return v % 512;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 320; my[i] = 240; md[i] = 1'b0;
    end
  endfunction

  // Expected per-cycle stream of one flush: every dirty entry in id order, X then Y.
  task automatic model_flush(output int d, output int k);
    exp_q.delete(); d = 0; k = -1;
    for (int i = 0; i < N; i++) begin
      if (md[i]) begin
        if (k < 0) k = i;
        d++;
        repeat (HOLD) exp_q.push_back(wr_t'{1'b0, 32'(i), 32'(mx[i])});
        repeat (HOLD) exp_q.push_back(wr_t'{1'b1, 32'(i), 32'(my[i])});
        md[i] = 1'b0;
      end
    end
  endtask

  task automatic cpu_write(input logic [31:0] id, input logic is_y, input logic [31:0] loc);
    bus.cpu_wren = 1'b1; bus.cpu_is_y = is_y; bus.cpu_dot_id = id; bus.cpu_loc = loc;
    @(posedge clk); #1;
    bus.cpu_wren = 1'b0;
    if (id < N) begin
      if (is_y) my[id] = fit_y(loc); else mx[id] = fit_x(loc);
      md[id] = 1'b1;
    end
  endtask

  // Starts a frame and records every dotWren cycle until the flush has settled.
  task automatic run_flush(input int retrig_at, input int inj_c, input logic [31:0] inj_id,
                           input logic [31:0] inj_loc, output int busy_n, output int fd_n,
                           output int first_wr, output bit timed_out);
    int end_c;
    cap.delete(); bad_idle = 0; busy_n = 0; fd_n = 0; first_wr = -1; timed_out = 1'b1; end_c = -1;
    screenEnd = 1'b1;
    for (int c = 1; c <= 1200; c++) begin
      @(posedge clk); #1;
      if (c == 3) screenEnd = 1'b0;
      if (retrig_at > 0 && c == retrig_at) screenEnd = 1'b1;
      if (retrig_at > 0 && c == retrig_at + 2) screenEnd = 1'b0;
      if (inj_c > 0 && c == inj_c) begin
        bus.cpu_wren = 1'b1; bus.cpu_is_y = 1'b0; bus.cpu_dot_id = inj_id; bus.cpu_loc = inj_loc;
      end
      if (inj_c > 0 && c == inj_c + 1) bus.cpu_wren = 1'b0;
      @(negedge clk);
      if (busy) busy_n++;
      if (frame_done) fd_n++;
      if (bus.dotWren) begin
        if (first_wr < 0) first_wr = c;
        cap.push_back(wr_t'{bus.is_Yloc, bus.dotID, bus.dotLoc});
      end else if (bus.is_Yloc || bus.dotID != 0 || bus.dotLoc != 0) begin
        bad_idle++;
      end
      if (fd_n > 0 && !busy && end_c < 0) end_c = c;
      if (end_c > 0 && c == end_c + 6) begin
        timed_out = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; screenEnd = 1'b0;
    bus.cpu_wren = 1'b0; bus.cpu_is_y = 1'b0; bus.cpu_dot_id = '0; bus.cpu_loc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.dotWren, bus.is_Yloc, busy, frame_done, id_err} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 00000", {bus.dotWren, bus.is_Yloc, busy, frame_done, id_err});
    end
    vectors++;
    if (bus.dotID !== 32'd0) begin miscompares++; $display("FAIL reset_dotID got %0d want 0", bus.dotID); end
    vectors++;
    if (bus.dotLoc !== 32'd0) begin miscompares++; $display("FAIL reset_dotLoc got %0d want 0", bus.dotLoc); end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_empty_flush();
    int d, k, busy_n, fd_n, first_wr; bit to;
    model_flush(d, k);
    run_flush(0, 0, 0, 0, busy_n, fd_n, first_wr, to);
    vectors++; if (to) begin miscompares++; $display("FAIL empty_timeout got busy_n=%0d want done", busy_n); end
    vectors++; if (first_wr != -1) begin miscompares++; $display("FAIL empty_wren got first=%0d want none", first_wr); end
    vectors++; if (fd_n != 1) begin miscompares++; $display("FAIL empty_frame_done got %0d want 1", fd_n); end
    vectors++;
    if (busy_n < N + 1 || busy_n > N + 2) begin
      miscompares++; $display("FAIL empty_busy got %0d want %0d..%0d", busy_n, N + 1, N + 2);
    end
  endtask

  task automatic test_single();
    int d, k, busy_n, fd_n, first_wr; bit to;
    cpu_write(5, 1'b0, 100);
    vectors++; if (id_err !== 1'b0) begin miscompares++; $display("FAIL single_id_err got %b want 0", id_err); end
    cpu_write(5, 1'b1, 200);
    model_flush(d, k);
    run_flush(0, 0, 0, 0, busy_n, fd_n, first_wr, to);
    vectors++; if (to) begin miscompares++; $display("FAIL single_timeout got busy_n=%0d want done", busy_n); end
    vectors++;
    if (cap.size() != exp_q.size()) begin
      miscompares++; $display("FAIL single_len got %0d want %0d", cap.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      vectors++;
      if (cap[i] !== exp_q[i]) begin miscompares++; $display("FAIL single_wr[%0d] got %h want %h", i, cap[i], exp_q[i]); end
    end
    vectors++; if (first_wr != k + 2) begin miscompares++; $display("FAIL single_latency got %0d want %0d", first_wr, k + 2); end
    vectors++; if (fd_n != 1) begin miscompares++; $display("FAIL single_frame_done got %0d want 1", fd_n); end
    vectors++; if (bad_idle != 0) begin miscompares++; $display("FAIL single_idle_bus got %0d want 0", bad_idle); end
    vectors++;
    if (busy_n < N + 1 + 2 * HOLD * d || busy_n > N + 2 + 2 * HOLD * d) begin
      miscompares++; $display("FAIL single_busy got %0d want %0d", busy_n, N + 1 + 2 * HOLD * d);
    end
  endtask

  task automatic test_back_to_back();
    int d, k, busy_n, fd_n, first_wr; bit to;
    cpu_write(69, 1'b0, 639);
    cpu_write(0, 1'b1, 17);
    cpu_write(69, 1'b1, 479);
    model_flush(d, k);
    run_flush(0, 0, 0, 0, busy_n, fd_n, first_wr, to);
    vectors++; if (to) begin miscompares++; $display("FAIL b2b_timeout got busy_n=%0d want done", busy_n); end
    vectors++;
    if (cap.size() != 16 || exp_q.size() != 16) begin
      miscompares++; $display("FAIL b2b_len got %0d want 16", cap.size());
    end else foreach (exp_q[i]) begin
      vectors++;
      if (cap[i] !== exp_q[i]) begin miscompares++; $display("FAIL b2b_wr[%0d] got %h want %h", i, cap[i], exp_q[i]); end
    end
    vectors++; if (first_wr != 2) begin miscompares++; $display("FAIL b2b_latency got %0d want 2", first_wr); end
    vectors++; if (fd_n != 1) begin miscompares++; $display("FAIL b2b_frame_done got %0d want 1", fd_n); end
    vectors++; if (bad_idle != 0) begin miscompares++; $display("FAIL b2b_idle_bus got %0d want 0", bad_idle); end
  endtask

  task automatic test_collision();
    int d, k, busy_n, fd_n, first_wr; bit to;
    cpu_write(3, 1'b0, 10);
    model_flush(d, k);
    // idx 3 is examined on the 5th edge after the frame starts; the write lands on that edge.
    run_flush(0, 4, 3, 50, busy_n, fd_n, first_wr, to);
    mx[3] = fit_x(50); md[3] = 1'b1;
    vectors++;
    if (to || cap.size() != exp_q.size()) begin
      miscompares++; $display("FAIL collide_len got %0d want %0d", cap.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      vectors++;
      if (cap[i] !== exp_q[i]) begin miscompares++; $display("FAIL collide_old[%0d] got %h want %h", i, cap[i], exp_q[i]); end
    end
    vectors++; if (first_wr != 5) begin miscompares++; $display("FAIL collide_latency got %0d want 5", first_wr); end
    model_flush(d, k);
    run_flush(0, 0, 0, 0, busy_n, fd_n, first_wr, to);
    vectors++;
    if (to || cap.size() != exp_q.size()) begin
      miscompares++; $display("FAIL collide_next_len got %0d want %0d", cap.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      vectors++;
      if (cap[i] !== exp_q[i]) begin miscompares++; $display("FAIL collide_new[%0d] got %h want %h", i, cap[i], exp_q[i]); end
    end
  endtask

  task automatic test_id_err_retrigger();
    int d, k, busy_n, fd_n, first_wr; bit to;
    cpu_write(70, 1'b0, 5);
    @(negedge clk);
    vectors++; if (id_err !== 1'b1) begin miscompares++; $display("FAIL id_err_pulse got %b want 1", id_err); end
    @(posedge clk); #1;
    cpu_write(32'h0000_0185, 1'b1, 7);
    @(negedge clk);
    vectors++; if (id_err !== 1'b1) begin miscompares++; $display("FAIL id_err_wide got %b want 1", id_err); end
    @(negedge clk);
    vectors++; if (id_err !== 1'b0) begin miscompares++; $display("FAIL id_err_len got %b want 0", id_err); end
    @(posedge clk); #1;
    model_flush(d, k);
    run_flush(20, 0, 0, 0, busy_n, fd_n, first_wr, to);
    vectors++; if (to) begin miscompares++; $display("FAIL retrig_timeout got busy_n=%0d want done", busy_n); end
    vectors++; if (cap.size() != 0) begin miscompares++; $display("FAIL id_err_table got %0d writes want 0", cap.size()); end
    vectors++; if (fd_n != 1) begin miscompares++; $display("FAIL retrig_frame_done got %0d want 1", fd_n); end
    vectors++;
    if (busy_n < N + 1 || busy_n > N + 2) begin
      miscompares++; $display("FAIL retrig_busy got %0d want %0d", busy_n, N + 1);
    end
  endtask

  task automatic test_random();
    int d, k, busy_n, fd_n, first_wr, n; bit to;
    logic [31:0] loc;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 25);
      for (int j = 0; j < n; j++) begin
        loc = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 700));
        cpu_write(32'($urandom_range(0, 74)), 1'($urandom_range(0, 1)), loc);
      end
      model_flush(d, k);
      run_flush(0, 0, 0, 0, busy_n, fd_n, first_wr, to);
      vectors++;
      if (to || cap.size() != exp_q.size()) begin
        miscompares++; $display("FAIL rand%0d_len got %0d want %0d", r, cap.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        vectors++;
        if (cap[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand%0d_wr[%0d] got %h want %h", r, i, cap[i], exp_q[i]); end
      end
      vectors++; if (first_wr != k + 2) begin miscompares++; $display("FAIL rand%0d_latency got %0d want %0d", r, first_wr, k + 2); end
      vectors++; if (fd_n != 1) begin miscompares++; $display("FAIL rand%0d_frame_done got %0d want 1", r, fd_n); end
      vectors++; if (bad_idle != 0) begin miscompares++; $display("FAIL rand%0d_idle_bus got %0d want 0", r, bad_idle); end
      vectors++;
      if (busy_n < N + 1 + 2 * HOLD * d || busy_n > N + 2 + 2 * HOLD * d) begin
        miscompares++; $display("FAIL rand%0d_busy got %0d want %0d", r, busy_n, N + 1 + 2 * HOLD * d);
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    int d, k, busy_n, fd_n, first_wr; bit to, seen;
    cpu_write(10, 1'b0, 111);
    cpu_write(10, 1'b1, 222);
    screenEnd = 1'b1; seen = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      if (c == 3) screenEnd = 1'b0;
      @(negedge clk);
      if (bus.is_Yloc) begin seen = 1'b1; break; end
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL rst_mid_reach got no SEND_Y want SEND_Y"); end
    @(posedge clk); #1;
    reset = 1'b1; screenEnd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++; if (bus.dotWren !== 1'b0) begin miscompares++; $display("FAIL rst_mid_wren got %b want 0", bus.dotWren); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    cpu_write(7, 1'b0, 33);
    model_flush(d, k);
    run_flush(0, 0, 0, 0, busy_n, fd_n, first_wr, to);
    vectors++;
    if (to || cap.size() != exp_q.size()) begin
      miscompares++; $display("FAIL rst_mid_len got %0d want %0d", cap.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      vectors++;
      if (cap[i] !== exp_q[i]) begin miscompares++; $display("FAIL rst_mid_wr[%0d] got %h want %h", i, cap[i], exp_q[i]); end
    end
  endtask

  task automatic test_clamp();
    int d, k, busy_n, fd_n, first_wr; bit to;
    int unsigned want_x, want_y;
`ifdef DOT_WRITER_CLAMP_EN
    want_x = 639; want_y = 479;
`else
    want_x = 1000; want_y = 500;
`endif
    cpu_write(12, 1'b0, 1000);
    cpu_write(12, 1'b1, 500);
    model_flush(d, k);
    run_flush(0, 0, 0, 0, busy_n, fd_n, first_wr, to);
    vectors++;
    if (to || cap.size() != 2 * HOLD) begin
      miscompares++; $display("FAIL clamp_len got %0d want %0d", cap.size(), 2 * HOLD);
    end else begin
      vectors++;
      if (cap[0].loc !== 32'(want_x)) begin miscompares++; $display("FAIL clamp_x got %0d want %0d", cap[0].loc, want_x); end
      vectors++;
      if (cap[HOLD].loc !== 32'(want_y)) begin miscompares++; $display("FAIL clamp_y got %0d want %0d", cap[HOLD].loc, want_y); end
    end
  endtask

  initial begin
    test_reset();
    test_empty_flush();
    test_single();
    test_back_to_back();
    test_collision();
    test_id_err_retrigger();
    test_random();
    test_reset_mid_flush();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
